if_fetch_unit: RTL and testbench

Instruction fetch initiator for the RISC-V core's IF stage. Owns the fetch PC and issues word requests to the instruction memory over a req/ack handshake that tolerates variable memory latency. Buffers returned instructions in a 2-entry queue and presents them to decode over a valid/ready interface. Supports redirects from execute (branch/jump) at any cycle, discarding in-flight responses.

---
 rtl/if_fetch_unit.sv | 148 ++++++++++++++
 tb/tb_if_fetch_unit.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// IF-stage fetch initiator: owns the fetch PC, issues word requests over a req/ack
// handshake, and buffers returned instructions in a 2-entry queue toward decode.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        id_ready
);

    typedef enum logic [1:0] {StIdle, StReq, StDrop} state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [31:0] head_pc_q, head_pc_d, head_instr_q, head_instr_d;
    logic [31:0] tail_pc_q, tail_pc_d, tail_instr_q, tail_instr_d;
    logic [1:0]  count_q, count_d;

    logic        pop;
    logic        push;
    logic [1:0]  count_after_pop;
    logic [31:0] target;
    logic [31:0] fetch_pc_inc;

    assign target       = {redirect_pc[31:2], 2'b00};
    assign fetch_pc_inc = fetch_pc_q + 32'd4;

    assign if_valid  = (count_q != 2'd0);
    assign if_pc     = head_pc_q;
    assign if_instr  = head_instr_q;
    assign imem_req  = (state_q != StIdle);
    assign imem_addr = req_addr_q;

    assign pop             = if_valid & id_ready;
    assign count_after_pop = count_q - {1'b0, pop};

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        req_addr_d   = req_addr_q;
        pend_pc_d    = pend_pc_q;
        head_pc_d    = head_pc_q;
        head_instr_d = head_instr_q;
        tail_pc_d    = tail_pc_q;
        tail_instr_d = tail_instr_q;
        count_d      = count_q;
        push         = 1'b0;

        case (state_q)
            StIdle: begin
                if (redirect_valid) begin
                    fetch_pc_d = target;
                    req_addr_d = target;
                    state_d    = StReq;
                end else if (count_after_pop < 2'd2) begin
                    req_addr_d = fetch_pc_q;
                    state_d    = StReq;
                end
            end
            StReq: begin
                if (redirect_valid) begin
                    if (imem_ack) begin
                        fetch_pc_d = target;
                        req_addr_d = target;
                    end else begin
                        pend_pc_d = target;
                        state_d   = StDrop;
                    end
                end else if (imem_ack) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc_inc;
                    // Queue becomes full after this push: stop requesting.
                    if (count_after_pop == 2'd1) begin
                        state_d = StIdle;
                    end else begin
                        req_addr_d = fetch_pc_inc;
                    end
                end
            end
            StDrop: begin
                if (imem_ack) begin
                    fetch_pc_d = redirect_valid ? target : pend_pc_q;
                    req_addr_d = redirect_valid ? target : pend_pc_q;
                    state_d    = StReq;
                end else if (redirect_valid) begin
                    pend_pc_d = target;
                end
            end
            default: state_d = StIdle;
        endcase

        if (redirect_valid) begin
            count_d = 2'd0;
        end else begin
            if (pop) begin
                head_pc_d    = tail_pc_q;
                head_instr_d = tail_instr_q;
            end
            // New entry lands right behind whatever survives the pop.
            if (push) begin
                if (count_after_pop == 2'd0) begin
                    head_pc_d    = req_addr_q;
                    head_instr_d = imem_rdata;
                end else begin
                    tail_pc_d    = req_addr_q;
                    tail_instr_d = imem_rdata;
                end
            end
            count_d = count_after_pop + {1'b0, push};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            fetch_pc_q   <= RESET_PC;
            req_addr_q   <= RESET_PC;
            pend_pc_q    <= RESET_PC;
            head_pc_q    <= 32'h0;
            head_instr_q <= 32'h0;
            tail_pc_q    <= 32'h0;
            tail_instr_q <= 32'h0;
            count_q      <= 2'd0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            req_addr_q   <= req_addr_d;
            pend_pc_q    <= pend_pc_d;
            head_pc_q    <= head_pc_d;
            head_instr_q <= head_instr_d;
            tail_pc_q    <= tail_pc_d;
            tail_instr_q <= tail_instr_d;
            count_q      <= count_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed stimulus pushes expected PCs into a scoreboard
// queue; a negedge monitor pops and compares on every decode acceptance.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        id_ready;

    int checks   = 0;
    int failures = 0;

    logic        mem_en;
    logic [3:0]  lat;
    logic [3:0]  wait_cnt;
    logic [31:0] exp_q[$];
    logic        prev_hold;
    logic [31:0] prev_addr;

    if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .if_instr      (if_instr),
        .id_ready      (id_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    // Memory model: acks once the request has waited 'lat' cycles.
    always @(posedge clk or negedge rst) begin
        if (!rst) wait_cnt <= 4'd0;
        else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 4'd1;
        else wait_cnt <= 4'd0;
    end
    assign imem_ack   = imem_req && mem_en && (wait_cnt >= lat);
    assign imem_rdata = mem_word(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (prev_hold) begin
                chk("hold_req", {31'b0, imem_req}, 32'd1);
                chk("hold_addr", imem_addr, prev_addr);
            end
            if (if_valid && id_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pop actual_pc=%h expected=none", if_pc);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    chk("sb_if_pc", if_pc, e);
                    chk("sb_if_instr", if_instr, mem_word(e));
                end
            end
            prev_hold = imem_req && !imem_ack;
            prev_addr = imem_addr;
        end else begin
            prev_hold = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b0;
        mem_en         = 1'b0;
        lat            = 4'd0;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic drain_check(input string name);
        repeat (3) tick();
        chk({name, "_sb_empty"}, exp_q.size(), 32'd0);
        chk({name, "_idle_valid"}, {31'b0, if_valid}, 32'd0);
    endtask

    initial begin
        prev_hold = 1'b0;
        prev_addr = 32'h0;

        // Reset values, then zero-wait streaming.
        do_reset();
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_instr", if_instr, 32'h0);
        mem_en   = 1'b1;
        id_ready = 1'b1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        exp_q.push_back(32'hC);
        release_reset();
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("zw_req", {31'b0, imem_req}, 32'd1);
            chk("zw_addr", imem_addr, 32'(4 * (k - 1)));
            if (k >= 2) begin
                chk("zw_valid", {31'b0, if_valid}, 32'd1);
                chk("zw_pc", if_pc, 32'(4 * (k - 2)));
            end
        end
        mem_en = 1'b0;
        drain_check("zw");

        // Decode stalled from reset: queue fills, then resumes at 8.
        do_reset();
        mem_en = 1'b1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        release_reset();
        tick();
        tick();
        tick();
        chk("full_req", {31'b0, imem_req}, 32'd0);
        chk("full_pc", if_pc, 32'h0);
        tick();
        tick();
        chk("full_req_hold", {31'b0, imem_req}, 32'd0);
        id_ready = 1'b1;
        tick();
        chk("resume_req", {31'b0, imem_req}, 32'd1);
        chk("resume_addr", imem_addr, 32'h8);
        chk("resume_pc", if_pc, 32'h4);
        tick();
        mem_en = 1'b0;
        chk("resume_pc2", if_pc, 32'h8);
        drain_check("full");

        // Three wait states per request.
        do_reset();
        mem_en   = 1'b1;
        lat      = 4'd3;
        id_ready = 1'b1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        release_reset();
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("lat_addr0", imem_addr, 32'h0);
            chk("lat_valid0", {31'b0, if_valid}, 32'd0);
        end
        for (int k = 5; k <= 8; k++) begin
            tick();
            chk("lat_addr4", imem_addr, 32'h4);
            if (k == 5) chk("lat_pc0", if_pc, 32'h0);
        end
        tick();
        mem_en = 1'b0;
        chk("lat_pc4", if_pc, 32'h4);
        drain_check("lat");

        // Redirect to 0x100 while 0x8 is waiting for its ack.
        do_reset();
        mem_en   = 1'b1;
        id_ready = 1'b1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h100);
        release_reset();
        tick();
        tick();
        tick();
        lat = 4'd2;
        chk("rd_addr8", imem_addr, 32'h8);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        chk("rd_drop_req", {31'b0, imem_req}, 32'd1);
        chk("rd_drop_addr", imem_addr, 32'h8);
        chk("rd_drop_valid", {31'b0, if_valid}, 32'd0);
        for (int k = 6; k <= 8; k++) begin
            tick();
            chk("rd_tgt_addr", imem_addr, 32'h100);
            chk("rd_tgt_valid", {31'b0, if_valid}, 32'd0);
        end
        tick();
        mem_en = 1'b0;
        chk("rd_tgt_ivalid", {31'b0, if_valid}, 32'd1);
        chk("rd_tgt_pc", if_pc, 32'h100);
        drain_check("rd");

        // Redirect coincident with ack, then redirects while draining.
        do_reset();
        mem_en   = 1'b1;
        id_ready = 1'b1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h40);
        release_reset();
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        tick();
        chk("rc_addr", imem_addr, 32'h200);
        chk("rc_valid", {31'b0, if_valid}, 32'd0);
        lat         = 4'd2;
        redirect_pc = 32'h80;
        tick();
        redirect_pc = 32'h40;
        chk("rc_drop_addr", imem_addr, 32'h200);
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("rc_latest_addr", imem_addr, 32'h40);
        chk("rc_latest_valid", {31'b0, if_valid}, 32'd0);
        tick();
        tick();
        tick();
        mem_en = 1'b0;
        chk("rc_pc", if_pc, 32'h40);
        drain_check("rc");

        // Asynchronous reset with a full queue, then mid-request.
        do_reset();
        mem_en = 1'b1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        release_reset();
        tick();
        tick();
        tick();
        chk("ar_full_valid", {31'b0, if_valid}, 32'd1);
        chk("ar_full_req", {31'b0, imem_req}, 32'd0);
        #1 rst = 1'b0;
        #1;
        chk("ar_valid", {31'b0, if_valid}, 32'd0);
        chk("ar_pc", if_pc, 32'h0);
        chk("ar_instr", if_instr, 32'h0);
        chk("ar_addr", imem_addr, 32'h0);
        exp_q.delete();
        id_ready = 1'b1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        release_reset();
        tick();
        chk("ar_restart_addr", imem_addr, 32'h0);
        tick();
        chk("ar_restart_pc", if_pc, 32'h0);
        tick();
        mem_en = 1'b0;
        chk("ar_pend_req", {31'b0, imem_req}, 32'd1);
        chk("ar_pend_addr", imem_addr, 32'h8);
        tick();
        #2 rst = 1'b0;
        #1;
        chk("ar_mid_req", {31'b0, imem_req}, 32'd0);
        chk("ar_mid_addr", imem_addr, 32'h0);
        chk("ar_sb_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
